// File: rtl/wisc_pipe_pkg.sv
// rtl/wisc_pipe_pkg.sv - shared pipeline types for the hazard controller
//
// Purpose: register-index type, hazard FSM state encoding and the R0 constant
//          used by hazard_ctrl and its bench.
// Ports:   none (package).
package wisc_pipe_pkg;

  typedef logic [3:0] reg_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } hz_state_t;

  localparam reg_idx_t REG_ZERO = 4'd0;

endpackage

// File: rtl/hazard_sat_cnt.sv
// rtl/hazard_sat_cnt.sv - saturating up-counter for hazard performance statistics
//
// Purpose: counts cycles with inc=1, sticks at all-ones, clears on reset.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   inc    in   count this cycle
//   count  out  W-bit count value
module hazard_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID/EX hazard controller: load-use bubble and ctrl-flow front-end drain
//
// Purpose: compares the decode instruction with ID/EX, inserts a one-cycle
//          bubble on load-use, and drains the front end after a branch/call/ret
//          until the PC updater resolves or DRAIN_CYCLES elapse.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds stall_cnt / drain_cnt).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_rs1, id_rs2             decode source registers
//   id_use_rs1, id_use_rs2     decode instruction reads rs1 / rs2
//   id_ctrl                    decode instruction is branch/call/ret
//   ex_MemRead, ex_reg_rd      ID/EX load flag and destination register
//   ex_pc_resolved             PC updater decided this cycle
//   pc_stall, ifid_stall       hold PC / hold IF/ID
//   ifid_flush, idex_flush     NOP into IF/ID / bubble into ID/EX
//   PC_hazard                  loop-back bit to ID/EX, 1 while draining
//   stall_cnt, drain_cnt       [HAZARD_PERF_CNT_EN] saturating cycle counters
module hazard_ctrl
  import wisc_pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_rs1,
  input  logic [3:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_ctrl,
  input  logic             ex_MemRead,
  input  logic [3:0]       ex_reg_rd,
  input  logic             ex_pc_resolved,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] drain_cnt,
`endif
  output logic             PC_hazard
);

  if ((DRAIN_CYCLES < 1) || (DRAIN_CYCLES > 15) || (CNT_W < 1)) begin : g_bad_cfg
    $error("hazard_ctrl: DRAIN_CYCLES must be 1..15 and CNT_W >= 1");
  end

  hz_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  // R0 never carries a producer, so a load targeting it cannot create a hazard.
  assign load_use = ex_MemRead && (reg_idx_t'(ex_reg_rd) != REG_ZERO) &&
                    ((id_use_rs1 && (id_rs1 == ex_reg_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_reg_rd)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // A ctrl instruction behind a load-use waits in ID for the bubble first.
        if (!load_use && id_ctrl) begin
          state_d = DRAIN;
          cnt_d   = 4'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        // cnt_q <= 1 also covers the unreachable cnt_q==0 so DRAIN can never stick.
        if (ex_pc_resolved || (cnt_q <= 4'd1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mealy outputs, forced low while reset is held.
  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    PC_hazard  = 1'b0;
    if (rst_n) begin
      if (state_q == DRAIN) begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        PC_hazard  = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc, drain_inc;
  assign stall_inc = (state_q == IDLE) && load_use;
  assign drain_inc = (state_q == DRAIN);

  hazard_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  hazard_sat_cnt #(.W(CNT_W)) u_drain_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drain_inc),
    .count (drain_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_rs1, id_rs2, ex_reg_rd;
  logic       id_use_rs1, id_use_rs2, id_ctrl, ex_MemRead, ex_pc_resolved;
  logic       pc_stall, ifid_stall, ifid_flush, idex_flush, PC_hazard;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, drain_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  // Expected output vector order: {pc_stall, ifid_stall, ifid_flush, idex_flush, PC_hazard}
  localparam logic [4:0] O_NONE  = 5'b00000;
  localparam logic [4:0] O_STALL = 5'b11010;
  localparam logic [4:0] O_DRAIN = 5'b10101;

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_ctrl        (id_ctrl),
    .ex_MemRead     (ex_MemRead),
    .ex_reg_rd      (ex_reg_rd),
    .ex_pc_resolved (ex_pc_resolved),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt      (stall_cnt),
    .drain_cnt      (drain_cnt),
`endif
    .PC_hazard      (PC_hazard)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_rs1 = 4'd0; id_rs2 = 4'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_ctrl = 1'b0; ex_MemRead = 1'b0; ex_reg_rd = 4'd0; ex_pc_resolved = 1'b0;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs are already applied; push the expectation, sample at negedge,
  // then advance to just after the next posedge.
  task automatic step(input string tag, input logic [4:0] exp);
    logic [4:0] obs, e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {pc_stall, ifid_stall, ifid_flush, idex_flush, PC_hazard};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_checks++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", t, obs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ex_MemRead = 1'b1; ex_reg_rd = 4'd5; id_rs2 = 4'd5; id_use_rs2 = 1'b1;
  endtask

  initial begin
    // 1: reset with random inputs
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      {id_rs1, id_rs2, ex_reg_rd} = 12'($urandom);
      {id_use_rs1, id_use_rs2, id_ctrl, ex_MemRead, ex_pc_resolved} = 5'($urandom);
      step($sformatf("reset_%0d", i), O_NONE);
    end
    rst_n = 1'b1;
    idle_inputs();
    step("post_reset_idle", O_NONE);

    // 2: load-use on rs2, then bubble in ID/EX
    set_load_use();
    step("load_use_rs2", O_STALL);
    idle_inputs();
    step("after_bubble", O_NONE);
    // load-use on rs1
    ex_MemRead = 1'b1; ex_reg_rd = 4'd9; id_rs1 = 4'd9; id_use_rs1 = 1'b1;
    step("load_use_rs1", O_STALL);
    idle_inputs();

    // 3: R0 and unused-operand cases
    ex_MemRead = 1'b1; ex_reg_rd = 4'd0; id_rs1 = 4'd0; id_use_rs1 = 1'b1;
    step("r0_no_hazard", O_NONE);
    ex_reg_rd = 4'd5; id_rs1 = 4'd5; id_use_rs1 = 1'b0;
    step("rs1_unused", O_NONE);
    ex_MemRead = 1'b0; id_use_rs1 = 1'b1;
    step("not_a_load", O_NONE);
    idle_inputs();
    ex_pc_resolved = 1'b1;
    step("resolved_in_idle", O_NONE);
    idle_inputs();

    // 4: drain runs full DRAIN_CYCLES; load-use ignored and id_ctrl in last cycle irrelevant
    id_ctrl = 1'b1;
    step("ctrl_enter", O_NONE);
    id_ctrl = 1'b0;
    step("drain4_c1", O_DRAIN);
    set_load_use();
    step("drain4_c2_lu_ignored", O_DRAIN);
    idle_inputs();
    id_ctrl = 1'b1;
    step("drain4_c3", O_DRAIN);
    id_ctrl = 1'b0;
    step("drain4_exit", O_NONE);

    // 5: early resolve in the second drain cycle
    id_ctrl = 1'b1;
    step("ctrl5_enter", O_NONE);
    id_ctrl = 1'b0;
    step("drain5_c1", O_DRAIN);
    ex_pc_resolved = 1'b1;
    step("drain5_c2_resolved", O_DRAIN);
    ex_pc_resolved = 1'b0;
    step("drain5_exit", O_NONE);

    // 6: load-use wins over id_ctrl, then drain, then reset mid-drain
    set_load_use();
    id_ctrl = 1'b1;
    step("lu_and_ctrl", O_STALL);
    idle_inputs();
    id_ctrl = 1'b1;
    step("ctrl6_enter", O_NONE);
    id_ctrl = 1'b0;
    step("drain6_c1", O_DRAIN);
`ifdef HAZARD_PERF_CNT_EN
    check_val("stall_cnt_before_rst", 32'(stall_cnt), 32'd3);
    check_val("drain_cnt_before_rst", 32'(drain_cnt), 32'd6);
`endif
    rst_n = 1'b0;
    step("drain6_c2_reset", O_NONE);
    rst_n = 1'b1;
    step("after_reset_idle", O_NONE);
`ifdef HAZARD_PERF_CNT_EN
    check_val("stall_cnt_after_rst", 32'(stall_cnt), 32'd0);
    check_val("drain_cnt_after_rst", 32'(drain_cnt), 32'd0);
`endif
    // still in IDLE: a fresh load-use stalls immediately
    set_load_use();
    step("lu_after_reset", O_STALL);
    idle_inputs();
    step("final_idle", O_NONE);

    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
